mux2_rr_arbiter: RTL

Two-requester round-robin arbiter that shares one 32-bit MUX2T1 datapath and one downstream consumer between two valid/ready sources. A registered FSM owns the MUX2T1 SEL line, and the selected word is captured into a one-entry output register. A granted source keeps ownership for up to MAX_BURST consecutive beats, then must yield if the other source is waiting. The block sits in front of any single-ported 32-bit sink, such as a write port or bus master, that two units must share.

---
 rtl/mux2_rr_arbiter_if.sv | 27 ++
 rtl/mux2_rr_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two valid/ready sources, the round-robin arbiter
// and the single downstream consumer. The arbiter connects through the slave
// modport; the environment driving sources/consumer uses the master modport.
interface mux2_rr_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             REQ0_VALID;
  logic [WIDTH-1:0] REQ0_DATA;
  logic             REQ0_READY;
  logic             REQ1_VALID;
  logic [WIDTH-1:0] REQ1_DATA;
  logic             REQ1_READY;
  logic             OUT_VALID;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_SRC;
  logic             OUT_READY;

  modport slave (
    input  REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA, OUT_READY,
    output REQ0_READY, REQ1_READY, OUT_VALID, OUT_DATA, OUT_SRC
  );

  modport master (
    output REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA, OUT_READY,
    input  REQ0_READY, REQ1_READY, OUT_VALID, OUT_DATA, OUT_SRC
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one MUX2T1 datapath and one
// output register. A grant lasts up to MAX_BURST accepted beats; at burst end
// the other source takes over if it is waiting, otherwise the current owner is
// re-granted with a fresh count. SEL of the mux is owned by the FSM state.

// Plain 2:1 word multiplexer: SEL=0 passes D0, SEL=1 passes D1.
module MUX2T1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             SEL,
  output logic [WIDTH-1:0] DOUT
);
  // Select the word of the granted source.
  always_comb begin
    DOUT = SEL ? D1 : D0;
  end
endmodule

module mux2_rr_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                CLK,
  input logic                RST_N,
  mux2_rr_arbiter_if.slave   bus
);
  localparam int unsigned    CW        = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0]  BEAT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CW-1:0]    beat_q, beat_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;

  logic             sel;
  logic             space;
  logic             ready0, ready1;
  logic             accept;
  logic             own_valid, other_valid;
  logic [WIDTH-1:0] mux_dout;

  MUX2T1 #(.WIDTH(WIDTH)) u_mux (
    .D0   (bus.REQ0_DATA),
    .D1   (bus.REQ1_DATA),
    .SEL  (sel),
    .DOUT (mux_dout)
  );

  // Handshake decode: grant owner, room in the output register, acceptance.
  always_comb begin
    sel         = (state_q == GRANT1);
    space       = !out_valid_q || bus.OUT_READY;
    ready0      = (state_q == GRANT0) && space && RST_N;
    ready1      = (state_q == GRANT1) && space && RST_N;
    accept      = (bus.REQ0_VALID && ready0) || (bus.REQ1_VALID && ready1);
    own_valid   = sel ? bus.REQ1_VALID : bus.REQ0_VALID;
    other_valid = sel ? bus.REQ0_VALID : bus.REQ1_VALID;
  end

  // Next grant, round-robin pointer and burst count.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (bus.REQ0_VALID && bus.REQ1_VALID) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (bus.REQ0_VALID) begin
          state_d = GRANT0;
        end else if (bus.REQ1_VALID) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_valid) begin
          // Owner went away: spend this cycle handing over (or going idle).
          last_d  = sel;
          beat_d  = '0;
          state_d = other_valid ? (sel ? GRANT0 : GRANT1) : IDLE;
        end else if (accept) begin
          if (beat_q == BEAT_LAST) begin
            // Burst end: the owner just transferred, so IDLE is never the
            // successor here; it is either the waiting peer or a re-grant.
            last_d  = sel;
            beat_d  = '0;
            state_d = other_valid ? (sel ? GRANT0 : GRANT1) : state_q;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // FSM state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // One-entry output register: load on accept, empty on consume-only.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_dout;
      out_src_q   <= sel;
    end else if (bus.OUT_READY) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.REQ0_READY = ready0;
  assign bus.REQ1_READY = ready1;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.OUT_DATA   = out_data_q;
  assign bus.OUT_SRC    = out_src_q;
endmodule
